video_sig_gen: RTL and testbench
================================

Name: video_sig_gen

Overview:
Raster timing generator driving every pixel-domain consumer in the video path, including the sprite/BRAM lookup stages. Produces hcount/vcount scan position, HDMI-style sync, active-draw, a new-frame strobe and a frame counter. Also emits copies of sync/active delayed by a parameterised stage count, so downstream pipelined lookups (BRAM address -> palette -> colour) stay aligned with their pixel data without local shift registers.

Parameters:
ACTIVE_H, 1280, active pixels per line
H_FRONT, 110, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BACK, 220, horizontal back porch (pixels)
ACTIVE_V, 720, active lines per frame
V_FRONT, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BACK, 20, vertical back porch (lines)
FPS, 60, frame counter modulus
DELAY_STAGES, 4, latency of the *_dly_out copies in cycles (>=1)

Ports:
pixel_clk_in  input  1  pixel clock, all logic on rising edge
rst_in  input  1  asynchronous active-low reset
hcount_out  output  11  horizontal position, 0..TOTAL_H-1
vcount_out  output  10  vertical position, 0..TOTAL_V-1
hs_out  output  1  horizontal sync, active high
vs_out  output  1  vertical sync, active high
ad_out  output  1  active draw
nf_out  output  1  one-cycle new-frame pulse
fc_out  output  6  frame count, 0..FPS-1
hs_dly_out  output  1  hs_out delayed DELAY_STAGES cycles
vs_dly_out  output  1  vs_out delayed DELAY_STAGES cycles
ad_dly_out  output  1  ad_out delayed DELAY_STAGES cycles

Behaviour:
- Clock and reset: one clock, pixel_clk_in; reset is asynchronous and active-low: rst_in low clears state immediately, independent of the clock.
- Derived constants: TOTAL_H = ACTIVE_H+H_FRONT+H_SYNC+H_BACK (1650); TOTAL_V = ACTIVE_V+V_FRONT+V_SYNC+V_BACK (750).
- Reset values while rst_in=0:
  - hcount_out=TOTAL_H-1, vcount_out=TOTAL_V-1.
  - hs_out=vs_out=ad_out=nf_out=0, fc_out=0.
  - All delay-pipe stages and *_dly_out = 0.
- First rising edge after release: outputs show (0,0) with ad_out=1 and nf_out=0. The reset-induced wrap never pulses nf_out or bumps fc_out.
- Counting:
  - hcount increments each cycle and wraps TOTAL_H-1 -> 0.
  - On that wrap, vcount increments and wraps TOTAL_V-1 -> 0.
  - No stall or enable input.
- All outputs are registered and decoded from the next-state counters, so every output is coherent with hcount_out/vcount_out in the same cycle. No combinational path from counters to outputs.
- Decode:
  - hs_out=1 iff ACTIVE_H+H_FRONT <= hcount < ACTIVE_H+H_FRONT+H_SYNC (1390..1429).
  - vs_out=1 iff ACTIVE_V+V_FRONT <= vcount < ACTIVE_V+V_FRONT+V_SYNC (725..729), for the whole line including horizontal blanking.
  - ad_out=1 iff hcount<ACTIVE_H and vcount<ACTIVE_V.
  - nf_out=1 for exactly one cycle, when (hcount,vcount)=(ACTIVE_H,ACTIVE_V), i.e. the first non-active pixel after the last active line.
- Frame counter: fc_out increments in the same cycle nf_out asserts (same edge), wrapping FPS-1 -> 0. Width fixed at 6 bits; FPS must be <=64.
- Delay pipe:
  - *_dly_out equals the corresponding undelayed output from exactly DELAY_STAGES cycles earlier.
  - For DELAY_STAGES=4, ad_dly_out rises 4 cycles after the first ad_out after reset.
- Reset mid-frame: all state returns to reset values asynchronously, including the pipe. The frame restarts at (0,0) on the first edge after release.
- Width rule: hcount/vcount compared unsigned at full port width; parameters must satisfy TOTAL_H<=2048 and TOTAL_V<=1024.

Test Plan:
- Reset release -> first edge: hcount=0, vcount=0, ad=1, nf=0, fc=0; hs_dly/vs_dly/ad_dly=0 for cycles 1-3, ad_dly=1 at cycle 4.
- Run one line -> hcount reaches 1649 then 0 with vcount 0->1; ad=1 for hcount 0..1279 only; hs=1 for exactly 40 cycles at hcount 1390..1429.
- Run to (1280,720) -> nf=1 for one cycle and fc 0->1 on that edge; vs=1 for vcount 725..729 (5*1650=8250 cycles); vcount wraps 749->0.
- Run 60 full frames (60*1650*750 cycles) -> fc goes 0..59 then back to 0; nf count = 60.
- Assert rst_in low mid-line at (500,300), asynchronously between edges -> outputs immediately at reset values; after release restart at (0,0); no spurious nf.
- Compare hs_dly/vs_dly/ad_dly against undelayed outputs shifted by DELAY_STAGES (re-run with DELAY_STAGES=1 and 4) -> exact match every cycle.

Source files
------------

// File: rtl/video_sig_gen_if.sv
// rtl/video_sig_gen_if.sv - raster scan position, sync and strobe bundle from video_sig_gen
interface video_sig_gen_if;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hs_out;
   logic        vs_out;
   logic        ad_out;
   logic        nf_out;
   logic [5:0]  fc_out;
   logic        hs_dly_out;
   logic        vs_dly_out;
   logic        ad_dly_out;

   modport master (
      output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
             hs_dly_out, vs_dly_out, ad_dly_out
   );

   modport slave (
      input hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
            hs_dly_out, vs_dly_out, ad_dly_out
   );
endinterface

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster timing generator with delayed sync/active copies
module video_sig_gen #(
   parameter int ACTIVE_H     = 1280,
   parameter int H_FRONT      = 110,
   parameter int H_SYNC       = 40,
   parameter int H_BACK       = 220,
   parameter int ACTIVE_V     = 720,
   parameter int V_FRONT      = 5,
   parameter int V_SYNC       = 5,
   parameter int V_BACK       = 20,
   parameter int FPS          = 60,
   parameter int DELAY_STAGES = 4
) (
   input  logic            pixel_clk_in,
   input  logic            rst_in,
   video_sig_gen_if.master vid
);
   localparam int TOTAL_H = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
   localparam int TOTAL_V = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST   = 11'(TOTAL_H - 1);
   localparam logic [9:0]  V_LAST   = 10'(TOTAL_V - 1);
   localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
   localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
   localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FRONT + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FRONT);
   localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FRONT + V_SYNC);
   localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        ad_q, ad_d;
   logic        nf_q, nf_d;
   logic [5:0]  fc_q, fc_d;

   // Each entry holds {hs, vs, ad}; entry DELAY_STAGES-1 is the oldest.
   logic [2:0]  pipe_q [DELAY_STAGES];

   always_comb begin
      h_d = h_q + 11'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = 11'd0;
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end

      // Decoding from the next-state counters keeps every flag aligned with
      // the counter value it will be registered alongside.
      hs_d = (h_d >= HS_START) && (h_d < HS_END);
      vs_d = (v_d >= VS_START) && (v_d < VS_END);
      ad_d = (h_d < H_ACT) && (v_d < V_ACT);
      nf_d = (h_d == H_ACT) && (v_d == V_ACT);

      fc_d = fc_q;
      if (nf_d) begin
         fc_d = (fc_q == FC_LAST) ? 6'd0 : fc_q + 6'd1;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         h_q  <= H_LAST;
         v_q  <= V_LAST;
         hs_q <= 1'b0;
         vs_q <= 1'b0;
         ad_q <= 1'b0;
         nf_q <= 1'b0;
         fc_q <= 6'd0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         ad_q <= ad_d;
         nf_q <= nf_d;
         fc_q <= fc_d;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DELAY_STAGES; i++) begin
            pipe_q[i] <= 3'b000;
         end
      end else begin
         pipe_q[0] <= {hs_q, vs_q, ad_q};
         for (int i = 1; i < DELAY_STAGES; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign vid.hcount_out = h_q;
   assign vid.vcount_out = v_q;
   assign vid.hs_out     = hs_q;
   assign vid.vs_out     = vs_q;
   assign vid.ad_out     = ad_q;
   assign vid.nf_out     = nf_q;
   assign vid.fc_out     = fc_q;
   assign vid.hs_dly_out = pipe_q[DELAY_STAGES-1][2];
   assign vid.vs_dly_out = pipe_q[DELAY_STAGES-1][1];
   assign vid.ad_dly_out = pipe_q[DELAY_STAGES-1][0];
endmodule

// File: tb/tb_video_sig_gen.sv
// tb/tb_video_sig_gen.sv - checks video_sig_gen against a scan-time model, with delays of 4 and 1
module tb_video_sig_gen;
   localparam int AH = 16, HF = 2, HSW = 3, HB = 4;
   localparam int AV = 6,  VF = 1, VSW = 2, VB = 1;
   localparam int FPS = 5;
   localparam int DA = 4, DB = 1;
   localparam int TH = AH + HF + HSW + HB;   // 25
   localparam int TV = AV + VF + VSW + VB;   // 10
   localparam int FRAME = TH * TV;           // 250
   localparam int NF_T = AV * TH + AH;       // 166

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc;

   video_sig_gen_if vid_a ();
   video_sig_gen_if vid_b ();

   video_sig_gen #(.ACTIVE_H(AH), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                   .ACTIVE_V(AV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                   .FPS(FPS), .DELAY_STAGES(DA))
      dut_a (.pixel_clk_in(clk), .rst_in(rst_n), .vid(vid_a.master));

   video_sig_gen #(.ACTIVE_H(AH), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                   .ACTIVE_V(AV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                   .FPS(FPS), .DELAY_STAGES(DB))
      dut_b (.pixel_clk_in(clk), .rst_in(rst_n), .vid(vid_b.master));

   always #5 clk = ~clk;

   // Cycles since reset release; -1 means the DUT still holds reset values.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= -1;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // {hs, vs, ad} at scan time t; zero before the first post-reset edge.
   function automatic logic [2:0] sync_at(input int t);
      int h, v;
      if (t < 0) return 3'b000;
      h = t % TH;
      v = (t / TH) % TV;
      return {h >= AH + HF && h < AH + HF + HSW,
              v >= AV + VF && v < AV + VF + VSW,
              h < AH && v < AV};
   endfunction

   function automatic int exp_fc(input int t);
      if (t < NF_T) return 0;
      return ((t - NF_T) / FRAME + 1) % FPS;
   endfunction

   task automatic check_inst(input string tag, input int d,
                             input int h_a, input int v_a, input int hs, input int vs,
                             input int ad, input int nf, input int fc,
                             input int hsd, input int vsd, input int add);
      logic [2:0] s, sd;
      int eh, ev;
      s  = sync_at(cyc);
      sd = sync_at(cyc - d);
      eh = (cyc < 0) ? TH - 1 : cyc % TH;
      ev = (cyc < 0) ? TV - 1 : (cyc / TH) % TV;
      check({tag, ".hcount"}, h_a, eh);
      check({tag, ".vcount"}, v_a, ev);
      check({tag, ".hs"}, hs, int'(s[2]));
      check({tag, ".vs"}, vs, int'(s[1]));
      check({tag, ".ad"}, ad, int'(s[0]));
      check({tag, ".nf"}, nf, int'(cyc >= 0 && eh == AH && ev == AV));
      check({tag, ".fc"}, fc, (cyc < 0) ? 0 : exp_fc(cyc));
      check({tag, ".hs_dly"}, hsd, int'(sd[2]));
      check({tag, ".vs_dly"}, vsd, int'(sd[1]));
      check({tag, ".ad_dly"}, add, int'(sd[0]));
   endtask

   always @(negedge clk) begin
      check_inst("a", DA, int'(vid_a.hcount_out), int'(vid_a.vcount_out), int'(vid_a.hs_out),
                 int'(vid_a.vs_out), int'(vid_a.ad_out), int'(vid_a.nf_out), int'(vid_a.fc_out),
                 int'(vid_a.hs_dly_out), int'(vid_a.vs_dly_out), int'(vid_a.ad_dly_out));
      check_inst("b", DB, int'(vid_b.hcount_out), int'(vid_b.vcount_out), int'(vid_b.hs_out),
                 int'(vid_b.vs_out), int'(vid_b.ad_out), int'(vid_b.nf_out), int'(vid_b.fc_out),
                 int'(vid_b.hs_dly_out), int'(vid_b.vs_dly_out), int'(vid_b.ad_dly_out));
   end

   int nf_cnt, hs_line0, vs_cnt, fc_max;

   initial begin
      repeat (3) @(negedge clk);
      check("rst.hcount", int'(vid_a.hcount_out), 24);
      check("rst.vcount", int'(vid_a.vcount_out), 9);
      check("rst.ad", int'(vid_a.ad_out), 0);
      #2 rst_n = 1'b1;

      @(posedge clk); #1;
      check("first.hcount", int'(vid_a.hcount_out), 0);
      check("first.vcount", int'(vid_a.vcount_out), 0);
      check("first.ad", int'(vid_a.ad_out), 1);
      check("first.nf", int'(vid_a.nf_out), 0);
      check("first.fc", int'(vid_a.fc_out), 0);
      check("first.ad_dly_a", int'(vid_a.ad_dly_out), 0);
      check("first.ad_dly_b", int'(vid_b.ad_dly_out), 0);
      @(posedge clk); #1;
      check("t1.ad_dly_b", int'(vid_b.ad_dly_out), 1);
      check("t1.ad_dly_a", int'(vid_a.ad_dly_out), 0);
      repeat (2) begin
         @(posedge clk); #1;
         check("t23.ad_dly_a", int'(vid_a.ad_dly_out), 0);
      end
      @(posedge clk); #1;
      check("t4.ad_dly_a", int'(vid_a.ad_dly_out), 1);

      nf_cnt = 0; hs_line0 = 0; vs_cnt = 0; fc_max = 0;
      do begin
         @(posedge clk); #1;
         nf_cnt += int'(vid_a.nf_out);
         vs_cnt += int'(vid_a.vs_out);
         if (cyc < TH) hs_line0 += int'(vid_a.hs_out);
         if (int'(vid_a.fc_out) > fc_max) fc_max = int'(vid_a.fc_out);
      end while (cyc < 6 * FRAME - 1);
      check("nf_pulses_6_frames", nf_cnt, 6);
      check("hs_width_line0", hs_line0, 3);
      check("vs_cycles_6_frames", vs_cnt, 300);
      check("fc_max", fc_max, 4);
      check("fc_after_wrap", int'(vid_a.fc_out), 1);

      while (cyc < 6 * FRAME + 3 * TH + 10) begin
         @(posedge clk); #1;
      end
      check("mid.hcount", int'(vid_a.hcount_out), 10);
      check("mid.vcount", int'(vid_a.vcount_out), 3);
      #2 rst_n = 1'b0;
      #1;
      check("async.hcount", int'(vid_a.hcount_out), 24);
      check("async.vcount", int'(vid_a.vcount_out), 9);
      check("async.fc", int'(vid_a.fc_out), 0);
      check("async.ad", int'(vid_a.ad_out), 0);
      check("async.ad_dly", int'(vid_a.ad_dly_out), 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      nf_cnt = 0;
      repeat (300) begin
         @(posedge clk); #1;
         nf_cnt += int'(vid_a.nf_out);
      end
      check("nf_after_rerst", nf_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
